// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined 64-bit core front end.
package cpu_pkg;

    localparam int ADDR_W     = 64;
    localparam int INST_W     = 32;
    localparam int INST_BYTES = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order storage for fetched instructions and their PCs.
// Head data is driven from storage; it reads as zero while the queue is empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output logic             out_valid,
    output fetch_entry_t     out_entry,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next pointers, count and storage; clear wins over push and pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid = (count_q != '0);
    assign out_entry = out_valid ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues credit-limited
// requests to instruction memory, buffers responses in order and drops
// responses that belong to a path abandoned by a branch redirect.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic              fifo_clear;
    logic              fifo_push;
    logic              fifo_pop;
    fetch_entry_t      fifo_push_entry;
    fetch_entry_t      fifo_out_entry;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic              req_fire;
    logic              rsp_fire;

    // Every accepted request reserves a queue slot, so count + inflight
    // bounds occupancy. Gating with reset keeps requests off during reset.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign imem_req_valid = reset && !redirect_valid
                            && (credit_used < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire       = imem_rsp_valid && (inflight_q != '0);

    // PC, credit and discard bookkeeping; redirect overrides everything.
    always_comb begin
        fetch_pc_d      = fetch_pc_q;
        rsp_pc_d        = rsp_pc_q;
        inflight_d      = inflight_q;
        discard_d       = discard_q;
        fifo_clear      = 1'b0;
        fifo_push       = 1'b0;
        fifo_pop        = 1'b0;
        fifo_push_entry = '{pc: rsp_pc_q, inst: imem_rsp_inst};
        if (redirect_valid) begin
            fifo_clear = 1'b1;
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            inflight_d = inflight_q - CNT_W'(rsp_fire);
            discard_d  = inflight_q - CNT_W'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(INST_BYTES);
            end
            if (rsp_fire) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CNT_W'(1);
                end else begin
                    fifo_push = 1'b1;
                    rsp_pc_d  = rsp_pc_q + ADDR_W'(INST_BYTES);
                end
            end
            inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
            fifo_pop   = out_valid && out_ready;
        end
    end

    // Front-end state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (fifo_clear),
        .push       (fifo_push),
        .push_entry (fifo_push_entry),
        .pop        (fifo_pop),
        .out_valid  (out_valid),
        .out_entry  (fifo_out_entry),
        .count      (fifo_count)
    );

    assign out_pc   = fifo_out_entry.pc;
    assign out_inst = fifo_out_entry.inst;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end with prefetch buffering for the pipelined 64-bit core. It owns the fetch PC, issues requests to the instruction memory through a valid/ready handshake, and buffers returned instructions with their PCs in an in-order queue. It hands them to the IF/ID pipeline register through a valid/ready handshake. A branch redirect from the MEM stage (pcSrc with its branch target) flushes the queue and discards in-flight responses.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 64'h0, first fetch address after reset
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  64  fetch address (byte address, word aligned)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  instruction returned (in order, ≥1 cycle after acceptance)
- imem_rsp_inst  in  32  returned instruction
- redirect_valid  in  1  branch taken (pcSrc)
- redirect_pc  in  64  branch target
- out_valid  out  1  queue head valid
- out_pc  out  64  PC of head instruction
- out_inst  out  32  head instruction
- out_ready  in  1  IF/ID accepts head (deasserted = stall)

## Operation
- State: fetch_pc, rsp_pc (PC of next accepted response), queue (count, rd/wr pointers), inflight (requests accepted, not yet returned), discard (in-flight responses to drop).
- Credit rule: imem_req_valid = (count + inflight < DEPTH) and not redirect_valid. The queue never overflows.
- Request accepted (valid & ready): fetch_pc += 4, inflight += 1.
- Response with discard > 0: dropped, discard −= 1, inflight −= 1.
- Response with discard = 0: entry {rsp_pc, imem_rsp_inst} written at wr pointer, rsp_pc += 4, inflight −= 1.
- Response with inflight = 0 is a protocol error: ignored, no state change.
- Pop (out_valid & out_ready): rd pointer advances, count −= 1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Redirect: has priority over everything else that cycle. Queue cleared (count 0, pointers 0). A pop that cycle is ignored. fetch_pc and rsp_pc are set to redirect_pc. discard is set to inflight after this cycle's response, and any response arriving that cycle is dropped. No request is issued that cycle.
- Arithmetic: PCs are 64-bit, +4 wraps modulo 2^64. Counters are $clog2(DEPTH+1) bits. Pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Reset values: imem_req_valid 0 while reset is low, imem_req_addr RESET_PC, out_valid 0, out_pc 0, out_inst 0, count/inflight/discard 0.
- First request is asserted in the first cycle after reset deasserts, with addr RESET_PC.
- Response-to-output latency: a response written in cycle N shows at out_* in N+1 when the queue was empty. There is no combinational bypass.
- Redirect-to-request latency: redirect in cycle N, request at redirect_pc in N+1.
- out_valid = (count ≠ 0). out_* are registered or driven from storage, never combinationally from imem_rsp_*.
- Once asserted, imem_req_valid and imem_req_addr hold until accepted, unless a redirect occurs.
- Reset asserted mid-operation clears all state immediately. Stale responses after reset are protocol violations, and the memory is reset alongside this block.

## Structure
- Shared package cpu_pkg: ADDR_W = 64, INST_W = 32, INST_BYTES = 4, and a fetch_entry_t struct {pc, inst}.
- Sub-module fetch_fifo holds the DEPTH × fetch_entry_t storage, pointers and count, with push/pop/clear ports. Top-level fetch_queue holds the PC, credit and discard logic.

## Test plan
- Reset, RESET_PC = 0, memory always ready with 1-cycle latency, out_ready = 1 -> out_pc sequence 0, 4, 8, 12…, one per cycle after a 2-cycle startup.
- out_ready = 0 for 10 cycles with DEPTH = 4 -> exactly 4 requests issued, then imem_req_valid = 0. count = 4 with no overflow, and output resumes in order when out_ready = 1.
- Redirect to 0x100 with 2 requests in flight at 3-cycle latency -> the next 2 responses are dropped. The first out_pc is 0x100 and out_valid stays 0 until then.
- Redirect in the same cycle as a response and a pop -> the response is dropped, the pop is ignored, and the queue is empty on the next cycle.
- imem_req_ready held low for 5 cycles -> imem_req_addr is stable the whole time and fetch_pc advances only on acceptance.
- Reset asserted while the queue holds 3 entries -> out_valid drops to 0 asynchronously, and after release the first request is at RESET_PC.
